// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : baud_tick_gen
// Purpose  : Baud-rate tick generator for the serial ADC link. Produces
//            single-cycle enables at OVERSAMPLE x baud, plus a mid-bit sample
//            pulse and a bit-boundary pulse. The divisor is fixed point
//            {int,frac} and can be changed at runtime. A resync request
//            realigns the phase to a start-bit edge.
// Ports    : baud_clk_in  - system clock (rising edge)
//            reset_n      - asynchronous active-low reset
//            enable       - count enable; low freezes all state
//            resync       - one-cycle phase realign request
//            div_wr       - one-cycle divisor write strobe
//            div_in       - new divisor {int[DIV_W], frac[FRAC_W]}
//            div_q        - active divisor readback
//            div_err      - pulse: last div_wr rejected (int < 2)
//            os_tick      - oversample enable pulse
//            sample_tick  - mid-bit pulse
//            bit_tick     - bit-boundary pulse
// Config   : BAUD_FRAC_EN - when defined, the fractional accumulator is
//            built; otherwise the period is always the integer divisor.
// Revision : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD_DEFAULT = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4
) (
  input  logic                    baud_clk_in,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    resync,
  input  logic                    div_wr,
  input  logic [DIV_W+FRAC_W-1:0] div_in,
  output logic [DIV_W+FRAC_W-1:0] div_q,
  output logic                    div_err,
  output logic                    os_tick,
  output logic                    sample_tick,
  output logic                    bit_tick
);

  localparam int DW    = DIV_W + FRAC_W;
  localparam int OSC_W = $clog2(OVERSAMPLE);

  // Rounded reset divisor: (2*num + den) / (2*den).
  localparam longint unsigned BAUD_OS = longint'(BAUD_DEFAULT) * longint'(OVERSAMPLE);
  localparam longint unsigned D0_RAW  =
    ((longint'(CLK_HZ) << (FRAC_W + 1)) + BAUD_OS) / (2 * BAUD_OS);

`ifdef BAUD_FRAC_EN
  localparam logic [DW-1:0] FRAC_MASK = {DW{1'b1}};
`else
  // Without the accumulator the fraction field is stored as zero.
  localparam logic [DW-1:0] FRAC_MASK = {DW{1'b1}} << FRAC_W;
`endif

  localparam logic [DW-1:0]    D0       = DW'(D0_RAW) & FRAC_MASK;
  localparam logic [OSC_W-1:0] OSC_MID  = OSC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OSC_W-1:0] OSC_LAST = OSC_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [OSC_W-1:0] osc_q, osc_d;
  logic [DW-1:0]    div_act_q, div_act_d;
  logic [DW-1:0]    div_p_q, div_p_d;
  logic             pend_q, pend_d;
  logic             os_tick_q, sample_tick_q, bit_tick_q, div_err_q;

  logic             carry;
  logic             apply;
  logic             terminal;
  logic             wr_ok;
  logic [DW-1:0]    wr_val;
  logic [DIV_W-1:0] period_last;

  assign wr_ok  = div_wr && (div_in[DW-1:FRAC_W] >= DIV_W'(2));
  assign wr_val = div_in & FRAC_MASK;

  // Last count of the current period: N-1, or N when the previous tick
  // carried out of the accumulator. >= keeps the counter safe if a smaller
  // divisor was loaded while the count was held.
  assign period_last = div_act_q[DW-1:FRAC_W] + {{(DIV_W-1){1'b0}}, carry} - DIV_W'(1);
  assign terminal    = enable && !resync && (cnt_q >= period_last);

  always_comb begin
    cnt_d     = cnt_q;
    osc_d     = osc_q;
    div_act_d = div_act_q;
    div_p_d   = div_p_q;
    pend_d    = pend_q;
    apply     = 1'b0;

    if (wr_ok) begin
      div_p_d = wr_val;
      pend_d  = 1'b1;
    end

    if (resync) begin
      // Realign phase; a pending (or simultaneous) divisor takes effect now.
      cnt_d  = '0;
      osc_d  = '0;
      pend_d = 1'b0;
      if (wr_ok) begin
        div_act_d = wr_val;
      end else if (pend_q) begin
        div_act_d = div_p_q;
      end
    end else if (!enable) begin
      // Counters are frozen, so a new divisor can be applied straight away.
      if (wr_ok) begin
        div_act_d = wr_val;
        pend_d    = 1'b0;
        apply     = 1'b1;
      end
    end else if (terminal) begin
      cnt_d = '0;
      osc_d = osc_q + OSC_W'(1);
      // Divisor changes land on a period boundary; a write in this very
      // cycle bypasses the pending register.
      if (wr_ok) begin
        div_act_d = wr_val;
        pend_d    = 1'b0;
        apply     = 1'b1;
      end else if (pend_q) begin
        div_act_d = div_p_q;
        pend_d    = 1'b0;
        apply     = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    if (resync || apply) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (terminal) begin
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, div_act_q[FRAC_W-1:0]};
    end
  end

  always_ff @(posedge baud_clk_in or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign carry = carry_q;
`else
  assign carry = 1'b0;
`endif

  always_ff @(posedge baud_clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      osc_q         <= '0;
      div_act_q     <= D0;
      div_p_q       <= D0;
      pend_q        <= 1'b0;
      os_tick_q     <= 1'b0;
      sample_tick_q <= 1'b0;
      bit_tick_q    <= 1'b0;
      div_err_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      osc_q         <= osc_d;
      div_act_q     <= div_act_d;
      div_p_q       <= div_p_d;
      pend_q        <= pend_d;
      // Tick decodes use the os count before it advances.
      os_tick_q     <= terminal;
      sample_tick_q <= terminal && (osc_q == OSC_MID);
      bit_tick_q    <= terminal && (osc_q == OSC_LAST);
      div_err_q     <= div_wr && !wr_ok;
    end
  end

  assign div_q       = div_act_q;
  assign div_err     = div_err_q;
  assign os_tick     = os_tick_q;
  assign sample_tick = sample_tick_q;
  assign bit_tick    = bit_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_baud_tick_gen
// Purpose  : Directed self-checking bench for baud_tick_gen (default
//            parameters). Expected values follow BAUD_FRAC_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_baud_tick_gen;

`ifdef BAUD_FRAC_EN
  localparam bit FRAC = 1'b1;
`else
  localparam bit FRAC = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        resync;
  logic        div_wr;
  logic [19:0] div_in;
  logic [19:0] div_q;
  logic        div_err;
  logic        os_tick;
  logic        sample_tick;
  logic        bit_tick;

  int n_total = 0;
  int n_bad   = 0;
  int sp[16];
  int sidx;
  int bidx;
  int cyc;
  int n;
  int seen;

  baud_tick_gen dut (
    .baud_clk_in (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .resync      (resync),
    .div_wr      (div_wr),
    .div_in      (div_in),
    .div_q       (div_q),
    .div_err     (div_err),
    .os_tick     (os_tick),
    .sample_tick (sample_tick),
    .bit_tick    (bit_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until the next os_tick, bounded.
  task automatic wait_os(input int limit, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!os_tick && cnt < limit);
    check("os_seen", {31'd0, os_tick}, 32'd1);
  endtask

  // Collect nt tick spacings plus the tick index of the first sample/bit pulse.
  task automatic run_ticks(input int nt);
    int k;
    cyc  = 0;
    sidx = 0;
    bidx = 0;
    for (int i = 1; i <= nt; i++) begin
      wait_os(1000, k);
      sp[i-1] = k;
      cyc += k;
      if (sample_tick && sidx == 0) sidx = i;
      if (bit_tick && bidx == 0) bidx = i;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    resync  = 1'b0;
    div_wr  = 1'b0;
    div_in  = '0;
    repeat (3) step();

    // Reset state
    check("rst_divq", 32'(div_q), FRAC ? 32'd5208 : 32'd5200);
    check("rst_os",   {31'd0, os_tick}, 32'd0);
    check("rst_err",  {31'd0, div_err}, 32'd0);
    check("rst_bit",  {31'd0, bit_tick | sample_tick}, 32'd0);

    // Default divisor: first tick at 325, fractional alternation, one bit
    reset_n = 1'b1;
    enable  = 1'b1;
    run_ticks(16);
    check("def_first", sp[0], 32'd325);
    check("def_sp2",   sp[1], 32'd325);
    check("def_sp3",   sp[2], FRAC ? 32'd326 : 32'd325);
    check("def_sidx",  sidx,  32'd8);
    check("def_bidx",  bidx,  32'd16);
    check("def_bitcyc", cyc,  FRAC ? 32'd5207 : 32'd5200);

    // Write {5,0} mid-period: held pending until the period ends
    repeat (9) step();
    div_wr = 1'b1;
    div_in = 20'h00050;
    step();
    div_wr = 1'b0;
    check("wr5_pend_divq", 32'(div_q), FRAC ? 32'd5208 : 32'd5200);
    wait_os(400, n);
    check("wr5_rest", n, FRAC ? 32'd316 : 32'd315);
    check("wr5_divq", 32'(div_q), 32'h50);
    wait_os(20, n);
    check("wr5_sp1", n, 32'd5);
    wait_os(20, n);
    check("wr5_sp2", n, 32'd5);

    // Rejected write {1,0}
    div_wr = 1'b1;
    div_in = 20'h00010;
    step();
    div_wr = 1'b0;
    check("rej_err", {31'd0, div_err}, 32'd1);
    step();
    check("rej_err_clr", {31'd0, div_err}, 32'd0);
    check("rej_divq", 32'(div_q), 32'h50);
    wait_os(20, n);
    check("rej_rest", n, 32'd3);
    wait_os(20, n);
    check("rej_sp", n, 32'd5);

    // Divisor {10,4}, then resync at cnt=3
    div_wr = 1'b1;
    div_in = 20'h000A4;
    step();
    div_wr = 1'b0;
    wait_os(20, n);
    check("a4_apply", n, 32'd4);
    check("a4_divq", 32'(div_q), FRAC ? 32'hA4 : 32'hA0);
    repeat (3) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("rs_notick", {31'd0, os_tick}, 32'd0);
    run_ticks(16);
    check("rs_first", sp[0], 32'd10);
    check("rs_sidx",  sidx,  32'd8);
    check("rs_bidx",  bidx,  32'd16);
    check("rs_bitcyc", cyc,  FRAC ? 32'd163 : 32'd160);

    // Enable low 50 cycles mid-period
    repeat (4) step();
    enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (os_tick || sample_tick || bit_tick) seen++;
    end
    check("dis_noticks", seen, 32'd0);
    enable = 1'b1;
    wait_os(40, n);
    check("dis_resume", n, FRAC ? 32'd7 : 32'd6);

    // Write while disabled applies at once
    enable = 1'b0;
    div_wr = 1'b1;
    div_in = 20'h00060;
    step();
    div_wr = 1'b0;
    check("dis_wr_divq", 32'(div_q), 32'h60);
    enable = 1'b1;
    wait_os(40, n);
    check("dis_wr_sp", n, 32'd6);

    // Divisor {7,15}
    enable = 1'b0;
    div_wr = 1'b1;
    div_in = 20'h0007F;
    step();
    div_wr = 1'b0;
    check("d7_divq", 32'(div_q), FRAC ? 32'h7F : 32'h70);
    enable = 1'b1;
    wait_os(40, n);
    check("d7_sp1", n, 32'd7);
    wait_os(40, n);
    check("d7_sp2", n, 32'd7);
    wait_os(40, n);
    check("d7_sp3", n, FRAC ? 32'd8 : 32'd7);

    // Write {2,0} (minimum legal) on a terminal cycle: bypass
    enable = 1'b0;
    div_wr = 1'b1;
    div_in = 20'h00040;
    step();
    div_wr = 1'b0;
    enable = 1'b1;
    repeat (3) step();
    div_wr = 1'b1;
    div_in = 20'h00020;
    step();
    div_wr = 1'b0;
    check("byp_tick", {31'd0, os_tick}, 32'd1);
    check("byp_divq", 32'(div_q), 32'h20);
    check("byp_err",  {31'd0, div_err}, 32'd0);
    wait_os(20, n);
    check("byp_sp1", n, 32'd2);
    wait_os(20, n);
    check("byp_sp2", n, 32'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
